// File: rtl/hamming_encoder_7_4_stream.sv
// Streaming Hamming(7,4) encoder. Each accepted byte becomes two 7-bit
// codewords: the low nibble first, then the high nibble (out_last=1).
// An optional single-bit error can be injected into both codewords of a
// byte for exercising downstream decoders.
module hamming_encoder_7_4_stream (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_byte,
    input  logic [2:0]  inject_pos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_codeword,
    output logic        out_last,
    output logic [15:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hi_nib_q, hi_nib_d;   // only the high nibble outlives the accept cycle
    logic [2:0]  inj_q, inj_d;
    logic [6:0]  cw_q, cw_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;
    logic [15:0] cnt_q, cnt_d;

    logic        in_xfer;
    logic        out_xfer;

    // Layout: {d3, d2, d1, P4, d0, P2, P1}, bit 0 = P1.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Injection is applied after parity generation, so the codeword carries
    // a genuine single-bit error at position pos (1-based).
    function automatic logic [6:0] inject(input logic [6:0] cw, input logic [2:0] pos);
        if (pos == 3'd0)
            return cw;
        return cw ^ (7'd1 << (pos - 3'd1));
    endfunction

    // Ready while idle, or while the final codeword of a byte is leaving,
    // which lets back-to-back bytes stream with no bubble.
    always_comb begin
        in_ready = ~rst & ((state_q == IDLE) | ((state_q == HI) & out_ready));
    end

    assign out_valid    = valid_q;
    assign out_codeword = cw_q;
    assign out_last     = last_q;
    assign cw_count     = cnt_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q & out_ready;

    // Next-state / next-output computation for the three-state sequencer.
    always_comb begin
        state_d  = state_q;
        hi_nib_d = hi_nib_q;
        inj_d    = inj_q;
        cw_d     = cw_q;
        last_d   = last_q;
        valid_d  = valid_q;
        cnt_d    = out_xfer ? cnt_q + 16'd1 : cnt_q;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    state_d  = LO;
                    hi_nib_d = in_byte[7:4];
                    inj_d    = inject_pos;
                    cw_d     = inject(encode(in_byte[3:0]), inject_pos);
                    last_d   = 1'b0;
                    valid_d  = 1'b1;
                end
            end
            LO: begin
                if (out_xfer) begin
                    state_d = HI;
                    cw_d    = inject(encode(hi_nib_q), inj_q);
                    last_d  = 1'b1;
                end
            end
            HI: begin
                if (out_xfer) begin
                    if (in_xfer) begin
                        state_d  = LO;
                        hi_nib_d = in_byte[7:4];
                        inj_d    = inject_pos;
                        cw_d     = inject(encode(in_byte[3:0]), inject_pos);
                        last_d   = 1'b0;
                        valid_d  = 1'b1;
                    end else begin
                        // codeword and last are left as-is while idle
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending codewords.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            hi_nib_q <= 4'h0;
            inj_q    <= 3'd0;
            cw_q     <= 7'd0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            cnt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            hi_nib_q <= hi_nib_d;
            inj_q    <= inj_d;
            cw_q     <= cw_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
